io_control: RTL and testbench

Sequencing controller for the canvas IO datapath, the block that turns brush counters into VGA pixel addresses. It accepts single-cycle draw requests (brush origin x, y) and erase requests, arbitrates between them, and drives the datapath's `draw`, `erase`, `count_reset` and `x_in`/`y_in` inputs. It also drives the VGA adapter's `plot` and `colour`, so that exactly one full brush or canvas sweep is written per accepted request.

---
 rtl/io_pkg.sv | 50 +++++
 rtl/io_control_if.sv | 32 +++
 rtl/io_clamp.sv | 28 ++
 rtl/io_control.sv | 169 ++++++++++++++++
 tb/tb_io_control.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared constants and types for the canvas IO controller and datapath.
// Holds brush/canvas dimensions, colours, canvas origin, the controller state
// enum and a coordinate payload struct, so datapath and controller agree.
package io_pkg;

    localparam int unsigned COORD_W  = 8;
    localparam int unsigned COLOUR_W = 3;
    localparam int unsigned PIX_W    = 15;

    localparam int unsigned DRAW_W  = 11;
    localparam int unsigned DRAW_H  = 15;
    localparam int unsigned ERASE_W = 145;
    localparam int unsigned ERASE_H = 193;

    localparam int unsigned DRAW_TOTAL  = DRAW_W * DRAW_H;
    localparam int unsigned ERASE_TOTAL = ERASE_W * ERASE_H;

    localparam logic [COLOUR_W-1:0] DRAW_COLOUR  = 3'b111;
    localparam logic [COLOUR_W-1:0] ERASE_COLOUR = 3'b000;

    localparam int unsigned CANVAS_X0 = 86;
    localparam int unsigned CANVAS_Y0 = 36;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        ERASE = 2'd2,
        DONE  = 2'd3
    } io_state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

    // Saturate v into [lo, hi].
    function automatic logic [COORD_W-1:0] clamp_coord(
        input logic [COORD_W-1:0] v,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/io_control_if.sv
// io_control_if: request/command bundle between a requester and io_control.
//   master: drives go_draw, go_erase, x_req, y_req; observes datapath/VGA side.
//   slave : io_control; drives draw, erase, count_reset, x_in, y_in, plot,
//           colour, busy, done.
interface io_control_if;
    import io_pkg::*;

    logic                go_draw;
    logic                go_erase;
    logic [COORD_W-1:0]  x_req;
    logic [COORD_W-1:0]  y_req;
    logic                draw;
    logic                erase;
    logic                count_reset;
    logic [COORD_W-1:0]  x_in;
    logic [COORD_W-1:0]  y_in;
    logic                plot;
    logic [COLOUR_W-1:0] colour;
    logic                busy;
    logic                done;

    modport master (
        output go_draw, go_erase, x_req, y_req,
        input  draw, erase, count_reset, x_in, y_in, plot, colour, busy, done
    );

    modport slave (
        input  go_draw, go_erase, x_req, y_req,
        output draw, erase, count_reset, x_in, y_in, plot, colour, busy, done
    );

endinterface

// File: rtl/io_clamp.sv
// io_clamp: combinational clamp keeping the brush origin inside the canvas.
//   x_raw, y_raw : requested brush origin
//   x_c, y_c     : origin saturated to [X0, X0+ERASE_W-DRAW_W] x [Y0, Y0+ERASE_H-DRAW_H]
module io_clamp
    import io_pkg::*;
#(
    parameter int unsigned DRAW_W  = io_pkg::DRAW_W,
    parameter int unsigned DRAW_H  = io_pkg::DRAW_H,
    parameter int unsigned ERASE_W = io_pkg::ERASE_W,
    parameter int unsigned ERASE_H = io_pkg::ERASE_H
) (
    input  logic [COORD_W-1:0] x_raw,
    input  logic [COORD_W-1:0] y_raw,
    output logic [COORD_W-1:0] x_c,
    output logic [COORD_W-1:0] y_c
);

    localparam int unsigned X_LO = CANVAS_X0;
    localparam int unsigned X_HI = CANVAS_X0 + ERASE_W - DRAW_W;
    localparam int unsigned Y_LO = CANVAS_Y0;
    localparam int unsigned Y_HI = CANVAS_Y0 + ERASE_H - DRAW_H;

    always_comb begin
        x_c = clamp_coord(x_raw, COORD_W'(X_LO), COORD_W'(X_HI));
        y_c = clamp_coord(y_raw, COORD_W'(Y_LO), COORD_W'(Y_HI));
    end

endmodule

// File: rtl/io_control.sv
// io_control: sequencing controller for the canvas IO datapath.
// Arbitrates single-cycle draw/erase requests (erase first), holds one pending
// slot of each kind while busy, and drives the datapath and VGA adapter so
// exactly one brush (DRAW_W x DRAW_H) or canvas (ERASE_W x ERASE_H) sweep is
// plotted per accepted request, followed by a one-cycle done pulse.
//   clock, resetn : clock, asynchronous active-low reset
//   bus (slave)   : go_draw/go_erase/x_req/y_req in; draw, erase, count_reset
//                   (active-low counter reset), x_in, y_in, plot, colour,
//                   busy, done out (all registered)
// Build option: define IO_CONTROL_CLAMP_EN to clamp the latched origin so the
// brush stays inside the canvas; otherwise coordinates pass through untouched.
module io_control
    import io_pkg::*;
#(
    parameter int unsigned         DRAW_W       = io_pkg::DRAW_W,
    parameter int unsigned         DRAW_H       = io_pkg::DRAW_H,
    parameter int unsigned         ERASE_W      = io_pkg::ERASE_W,
    parameter int unsigned         ERASE_H      = io_pkg::ERASE_H,
    parameter logic [COLOUR_W-1:0] DRAW_COLOUR  = io_pkg::DRAW_COLOUR,
    parameter logic [COLOUR_W-1:0] ERASE_COLOUR = io_pkg::ERASE_COLOUR
) (
    input  logic         clock,
    input  logic         resetn,
    io_control_if.slave  bus
);

    localparam int unsigned DRAW_LAST  = DRAW_W * DRAW_H - 1;
    localparam int unsigned ERASE_LAST = ERASE_W * ERASE_H - 1;

    io_state_e          state_q, state_n;
    logic [PIX_W-1:0]   pix_q, pix_n;
    logic               erase_pend_q, erase_pend_n;
    logic               draw_pend_q, draw_pend_n;
    coord_t             pend_q, pend_n;
    coord_t             origin_q, origin_n;

    logic [COORD_W-1:0] sel_x_c, sel_y_c;
    logic [COORD_W-1:0] lat_x_c, lat_y_c;

    // A fresh request's coordinates win over the pending slot.
    always_comb begin
        sel_x_c = bus.go_draw ? bus.x_req : pend_q.x;
        sel_y_c = bus.go_draw ? bus.y_req : pend_q.y;
    end

`ifdef IO_CONTROL_CLAMP_EN
    io_clamp #(
        .DRAW_W  (DRAW_W),
        .DRAW_H  (DRAW_H),
        .ERASE_W (ERASE_W),
        .ERASE_H (ERASE_H)
    ) u_clamp (
        .x_raw (sel_x_c),
        .y_raw (sel_y_c),
        .x_c   (lat_x_c),
        .y_c   (lat_y_c)
    );
`else
    always_comb begin
        lat_x_c = sel_x_c;
        lat_y_c = sel_y_c;
    end
`endif

    // State, pixel counter, pending slots and latched origin.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            pix_q        <= '0;
            erase_pend_q <= 1'b0;
            draw_pend_q  <= 1'b0;
            pend_q       <= '0;
            origin_q     <= '0;
        end else begin
            state_q      <= state_n;
            pix_q        <= pix_n;
            erase_pend_q <= erase_pend_n;
            draw_pend_q  <= draw_pend_n;
            pend_q       <= pend_n;
            origin_q     <= origin_n;
        end
    end

    // Next-state, arbitration and pending-slot capture.
    always_comb begin
        state_n      = state_q;
        pix_n        = '0;
        erase_pend_n = erase_pend_q;
        draw_pend_n  = draw_pend_q;
        pend_n       = pend_q;
        origin_n     = origin_q;

        unique case (state_q)
            IDLE: begin
                if (bus.go_erase || erase_pend_q) begin
                    state_n      = ERASE;
                    erase_pend_n = 1'b0;
                    // Draw arriving alongside an erase waits its turn.
                    if (bus.go_draw) begin
                        draw_pend_n = 1'b1;
                        pend_n      = '{x: bus.x_req, y: bus.y_req};
                    end
                end else if (bus.go_draw || draw_pend_q) begin
                    state_n     = DRAW;
                    draw_pend_n = 1'b0;
                    origin_n    = '{x: lat_x_c, y: lat_y_c};
                end
            end
            DRAW: begin
                if (pix_q == PIX_W'(DRAW_LAST))
                    state_n = DONE;
                else
                    pix_n = pix_q + PIX_W'(1);
            end
            ERASE: begin
                if (pix_q == PIX_W'(ERASE_LAST))
                    state_n = DONE;
                else
                    pix_n = pix_q + PIX_W'(1);
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // While busy, requests park in the pending slots; newest draw wins.
        if (state_q != IDLE) begin
            if (bus.go_erase)
                erase_pend_n = 1'b1;
            if (bus.go_draw) begin
                draw_pend_n = 1'b1;
                pend_n      = '{x: bus.x_req, y: bus.y_req};
            end
        end
    end

    // Outputs are flopped decodes of the next state so they align with state_q.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bus.draw        <= 1'b0;
            bus.erase       <= 1'b0;
            bus.count_reset <= 1'b0;
            bus.plot        <= 1'b0;
            bus.colour      <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            bus.draw        <= (state_n == DRAW);
            bus.erase       <= (state_n == ERASE);
            bus.count_reset <= (state_n == DRAW) || (state_n == ERASE);
            bus.plot        <= (state_n == DRAW) || (state_n == ERASE);
            bus.busy        <= (state_n != IDLE);
            bus.done        <= (state_n == DONE);
            if (state_n == DRAW)
                bus.colour <= DRAW_COLOUR;
            else if (state_n == ERASE)
                bus.colour <= ERASE_COLOUR;
            else
                bus.colour <= '0;
        end
    end

    assign bus.x_in = origin_q.x;
    assign bus.y_in = origin_q.y;

endmodule

// File: tb/tb_io_control.sv
// tb_io_control: directed self-checking bench for io_control, with a small
// model of the datapath brush/canvas counters to recover plotted pixels.
module tb_io_control;
    import io_pkg::*;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    io_control_if bus();

    io_control dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;

    // Datapath counter model: x wraps first, y advances on x wrap.
    logic [7:0] xc, yc, px, py;
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            xc <= 8'd0; yc <= 8'd0;
        end else if (!bus.count_reset) begin
            xc <= 8'd0; yc <= 8'd0;
        end else if (bus.draw) begin
            if (xc == 8'd10) begin
                xc <= 8'd0;
                yc <= (yc == 8'd14) ? 8'd0 : yc + 8'd1;
            end else xc <= xc + 8'd1;
        end else if (bus.erase) begin
            if (xc == 8'd144) begin
                xc <= 8'd0;
                yc <= (yc == 8'd192) ? 8'd0 : yc + 8'd1;
            end else xc <= xc + 8'd1;
        end
    end
    assign px = bus.erase ? 8'd86 + xc : bus.x_in + xc;
    assign py = bus.erase ? 8'd36 + yc : bus.y_in + yc;

    // Observations of one operation.
    int         n, wn;
    logic [2:0] c_or, c_and;
    logic [7:0] fx, fy, lx, ly;
    logic       done0, done1, busy0, busy1;
    bit         to;

    task automatic pulse(input logic d, input logic e, input logic [7:0] x, input logic [7:0] y);
        @(negedge clock);
        bus.go_draw = d; bus.go_erase = e; bus.x_req = x; bus.y_req = y;
        @(posedge clock);
        #1;
        bus.go_draw = 1'b0; bus.go_erase = 1'b0;
    endtask

    // Gather one plot burst and the two cycles after it (no checking here).
    task automatic watch_op();
        to = 0; n = 0; wn = 0; c_or = 3'b000; c_and = 3'b111;
        fx = 0; fy = 0; lx = 0; ly = 0; done0 = 0; done1 = 0; busy0 = 0; busy1 = 0;
        do begin
            @(negedge clock);
            wn++;
        end while (!bus.plot && wn < 20);
        if (!bus.plot) begin to = 1; return; end
        fx = px; fy = py;
        while (bus.plot && n < 30000) begin
            n++;
            c_or  = c_or | bus.colour;
            c_and = c_and & bus.colour;
            lx = px; ly = py;
            @(negedge clock);
        end
        if (bus.plot) begin to = 1; return; end
        done0 = bus.done; busy0 = bus.busy;
        @(negedge clock);
        done1 = bus.done; busy1 = bus.busy;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.go_draw = 0; bus.go_erase = 0; bus.x_req = 0; bus.y_req = 0;
        repeat (3) @(negedge clock);
        tests++; if (bus.plot !== 1'b0) begin fails++; $display("FAIL reset_plot: got %b want 0", bus.plot); end
        tests++; if (bus.draw !== 1'b0) begin fails++; $display("FAIL reset_draw: got %b want 0", bus.draw); end
        tests++; if (bus.erase !== 1'b0) begin fails++; $display("FAIL reset_erase: got %b want 0", bus.erase); end
        tests++; if (bus.count_reset !== 1'b0) begin fails++; $display("FAIL reset_count_reset: got %b want 0", bus.count_reset); end
        tests++; if (bus.colour !== 3'd0) begin fails++; $display("FAIL reset_colour: got %0d want 0", bus.colour); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.done); end
        tests++; if (bus.x_in !== 8'd0 || bus.y_in !== 8'd0) begin fails++; $display("FAIL reset_origin: got (%0d,%0d) want (0,0)", bus.x_in, bus.y_in); end
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_draw();
        pulse(1'b1, 1'b0, 8'd100, 8'd50);
        watch_op();
        tests++; if (to !== 1'b0) begin fails++; $display("FAIL draw_timeout: got %b want 0", to); end
        tests++; if (wn !== 1) begin fails++; $display("FAIL draw_latency: got %0d want 1", wn); end
        tests++; if (n !== 165) begin fails++; $display("FAIL draw_count: got %0d want 165", n); end
        tests++; if (c_or !== 3'd7 || c_and !== 3'd7) begin fails++; $display("FAIL draw_colour: got or=%0d and=%0d want 7", c_or, c_and); end
        tests++; if (fx !== 8'd100 || fy !== 8'd50) begin fails++; $display("FAIL draw_first: got (%0d,%0d) want (100,50)", fx, fy); end
        tests++; if (lx !== 8'd110 || ly !== 8'd64) begin fails++; $display("FAIL draw_last: got (%0d,%0d) want (110,64)", lx, ly); end
        tests++; if (done0 !== 1'b1 || busy0 !== 1'b1) begin fails++; $display("FAIL draw_done: got done=%b busy=%b want 1 1", done0, busy0); end
        tests++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin fails++; $display("FAIL draw_after: got done=%b busy=%b want 0 0", done1, busy1); end
        tests++; if (xc !== 8'd0 || yc !== 8'd0) begin fails++; $display("FAIL draw_wrap: got (%0d,%0d) want (0,0)", xc, yc); end
        tests++; if (bus.x_in !== 8'd100 || bus.y_in !== 8'd50) begin fails++; $display("FAIL draw_origin: got (%0d,%0d) want (100,50)", bus.x_in, bus.y_in); end
    endtask

    task automatic test_erase_then_draw();
        pulse(1'b1, 1'b1, 8'd90, 8'd40);
        watch_op();
        tests++; if (to !== 1'b0) begin fails++; $display("FAIL erase_timeout: got %b want 0", to); end
        tests++; if (n !== 27985) begin fails++; $display("FAIL erase_count: got %0d want 27985", n); end
        tests++; if (c_or !== 3'd0) begin fails++; $display("FAIL erase_colour: got %0d want 0", c_or); end
        tests++; if (fx !== 8'd86 || fy !== 8'd36) begin fails++; $display("FAIL erase_first: got (%0d,%0d) want (86,36)", fx, fy); end
        tests++; if (lx !== 8'd230 || ly !== 8'd228) begin fails++; $display("FAIL erase_last: got (%0d,%0d) want (230,228)", lx, ly); end
        tests++; if (done0 !== 1'b1 || done1 !== 1'b0) begin fails++; $display("FAIL erase_done: got %b%b want 10", done0, done1); end
        watch_op();
        tests++; if (wn !== 1) begin fails++; $display("FAIL pend_gap: got %0d want 1", wn); end
        tests++; if (n !== 165 || c_and !== 3'd7) begin fails++; $display("FAIL pend_draw: got n=%0d col=%0d want 165 7", n, c_and); end
        tests++; if (fx !== 8'd90 || fy !== 8'd40) begin fails++; $display("FAIL pend_first: got (%0d,%0d) want (90,40)", fx, fy); end
        tests++; if (lx !== 8'd100 || ly !== 8'd54) begin fails++; $display("FAIL pend_last: got (%0d,%0d) want (100,54)", lx, ly); end
        tests++; if (done0 !== 1'b1 || busy1 !== 1'b0) begin fails++; $display("FAIL pend_done: got done=%b busy=%b want 1 0", done0, busy1); end
    endtask

    task automatic test_draw_during_erase();
        int extra;
        pulse(1'b0, 1'b1, 8'd0, 8'd0);
        fork
            watch_op();
            begin
                repeat (50) @(negedge clock);
                pulse(1'b1, 1'b0, 8'd20, 8'd20);
                repeat (50) @(negedge clock);
                pulse(1'b1, 1'b0, 8'd120, 8'd120);
            end
        join
        tests++; if (n !== 27985) begin fails++; $display("FAIL overwrite_erase: got %0d want 27985", n); end
        watch_op();
        tests++; if (n !== 165) begin fails++; $display("FAIL overwrite_count: got %0d want 165", n); end
        tests++; if (fx !== 8'd120 || fy !== 8'd120) begin fails++; $display("FAIL overwrite_first: got (%0d,%0d) want (120,120)", fx, fy); end
        tests++; if (lx !== 8'd130 || ly !== 8'd134) begin fails++; $display("FAIL overwrite_last: got (%0d,%0d) want (130,134)", lx, ly); end
        extra = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.plot) extra++;
        end
        tests++; if (extra !== 0) begin fails++; $display("FAIL overwrite_single: got %0d extra plot cycles want 0", extra); end
    endtask

    task automatic test_reset_mid_draw();
        int extra;
        pulse(1'b1, 1'b0, 8'd100, 8'd100);
        repeat (40) @(negedge clock);
        pulse(1'b0, 1'b1, 8'd0, 8'd0);
        repeat (40) @(negedge clock);
        tests++; if (bus.plot !== 1'b1 || px !== 8'd103 || py !== 8'd107) begin fails++; $display("FAIL mid_pixel80: got plot=%b (%0d,%0d) want 1 (103,107)", bus.plot, px, py); end
        resetn = 1'b0;
        #1;
        tests++; if (bus.plot !== 1'b0 || bus.count_reset !== 1'b0) begin fails++; $display("FAIL abort_outputs: got plot=%b count_reset=%b want 0 0", bus.plot, bus.count_reset); end
        tests++; if (bus.busy !== 1'b0 || bus.draw !== 1'b0) begin fails++; $display("FAIL abort_state: got busy=%b draw=%b want 0 0", bus.busy, bus.draw); end
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        extra = 0;
        repeat (10) begin
            @(negedge clock);
            if (bus.plot) extra++;
        end
        tests++; if (extra !== 0) begin fails++; $display("FAIL abort_pending: got %0d plot cycles want 0", extra); end
        pulse(1'b1, 1'b0, 8'd100, 8'd100);
        watch_op();
        tests++; if (n !== 165 || fx !== 8'd100 || fy !== 8'd100) begin fails++; $display("FAIL restart: got n=%0d (%0d,%0d) want 165 (100,100)", n, fx, fy); end
    endtask

    task automatic test_clamp();
        logic [7:0] ex, ey;
`ifdef IO_CONTROL_CLAMP_EN
        ex = 8'd220; ey = 8'd36;
`else
        ex = 8'd250; ey = 8'd10;
`endif
        pulse(1'b1, 1'b0, 8'd250, 8'd10);
        watch_op();
        tests++; if (bus.x_in !== ex || bus.y_in !== ey) begin fails++; $display("FAIL clamp_origin: got (%0d,%0d) want (%0d,%0d)", bus.x_in, bus.y_in, ex, ey); end
        tests++; if (n !== 165 || done0 !== 1'b1) begin fails++; $display("FAIL clamp_op: got n=%0d done=%b want 165 1", n, done0); end
    endtask

    initial begin
        test_reset();
        test_draw();
        test_erase_then_draw();
        test_draw_during_erase();
        test_reset_mid_draw();
        test_clamp();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
